// File: rtl/prog_load_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prog_load_pkg
//  Description : Shared definitions for the program-load controller: the
//                controller state encoding, the frame sync byte and the
//                external status codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package prog_load_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_LO   = 3'd2,
        ST_HI   = 3'd3,
        ST_CSUM = 3'd4,
        ST_RUN  = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;

    localparam logic [1:0] STATUS_IDLE = 2'b00;
    localparam logic [1:0] STATUS_LOAD = 2'b01;
    localparam logic [1:0] STATUS_RUN  = 2'b10;
    localparam logic [1:0] STATUS_ERR  = 2'b11;

    // Map a controller state onto the 2-bit status code seen by software.
    function automatic logic [1:0] state_status(input state_t s);
        logic [1:0] r;
        r = STATUS_LOAD;
        case (s)
            ST_IDLE: r = STATUS_IDLE;
            ST_RUN:  r = STATUS_RUN;
            ST_ERR:  r = STATUS_ERR;
            default: r = STATUS_LOAD;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prog_load_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : prog_load_ctrl_if
//  Description : Byte-stream input and instruction-memory write bus of the
//                program-load controller.
//  Ports       : rx_data/rx_valid/rx_ready - byte stream (accept on valid&ready)
//                mem_we/mem_addr/mem_wdata - word write port
//  Modports    : master - environment side (byte source, memory)
//                slave  - controller side
//  Revision    : 1.0 - initial release
// ============================================================================
interface prog_load_ctrl_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/prog_load_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : CPU clock-enable generator. Free-run mode emits one cpu_ce
//                pulse every TICK_DIV cycles; step mode echoes each step pulse
//                one cycle later.
//  Ports       : clk, rst       - clock, asynchronous active-high reset
//                enable         - CPU is allowed to run
//                step_mode      - 1 = single step, 0 = free run
//                step           - single-cycle step request
//                cpu_ce         - registered clock-enable pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int unsigned TICK_DIV = 4_000_000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic enable,
    input  wire logic step_mode,
    input  wire logic step,
    output logic      cpu_ce
);
    localparam int unsigned     CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic             step_mode_q, step_mode_d;

    always_comb begin
        step_mode_d = step_mode;
        div_cnt_d   = '0;
        cpu_ce_d    = 1'b0;
        // A mode change restarts the divider and suppresses a pulse, so the
        // CPU never sees a stray tick from the mode it just left.
        if (enable && (step_mode == step_mode_q)) begin
            if (step_mode) begin
                cpu_ce_d = step;
            end else if (div_cnt_q == CNT_LAST) begin
                cpu_ce_d = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q   <= '0;
            cpu_ce_q    <= 1'b0;
            step_mode_q <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            cpu_ce_q    <= cpu_ce_d;
            step_mode_q <= step_mode_d;
        end
    end

    assign cpu_ce = cpu_ce_q;

endmodule
`default_nettype wire

// File: rtl/prog_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : prog_load_ctrl
//  Description : Boot sequencer for the 8-bit LED CPU. Parses a framed byte
//                stream (A5, N, N x {lo,hi}, checksum), writes the words into
//                instruction memory, then releases the CPU and schedules its
//                execution via tick_gen.
//  Ports       : clk, rst   - clock, asynchronous active-high reset
//                bus        - byte stream in / memory write out (slave side)
//                load_req   - pulse: abort and restart loading
//                step_mode  - 1 = single step, 0 = free run
//                step       - single-step pulse
//                cpu_rst_n  - CPU reset (active low)
//                cpu_ce     - CPU clock enable
//                boot_mode  - high whenever the CPU is not running
//                status     - 00 idle, 01 loading, 10 run, 11 error
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_load_ctrl
    import prog_load_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned TIMEOUT  = 1_000_000,
    parameter int unsigned TICK_DIV = 4_000_000
) (
    input  wire logic          clk,
    input  wire logic          rst,
    prog_load_ctrl_if.slave    bus,
    input  wire logic          load_req,
    input  wire logic          step_mode,
    input  wire logic          step,
    output logic               cpu_rst_n,
    output logic               cpu_ce,
    output logic               boot_mode,
    output logic [1:0]         status
);
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        lo_q, lo_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        widx_q, widx_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic              rx_ready_q, rx_ready_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              boot_mode_q, boot_mode_d;
    logic [1:0]        status_q, status_d;

    logic              accept;
    logic              in_frame;
    logic              run_en;

    assign accept   = bus.rx_valid & rx_ready_q;
    assign in_frame = (state_q == ST_LEN) || (state_q == ST_LO) ||
                      (state_q == ST_HI)  || (state_q == ST_CSUM);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        lo_d        = lo_q;
        csum_d      = csum_q;
        widx_d      = widx_q;
        to_cnt_d    = to_cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (load_req) begin
            // Abort wins over any byte accepted this cycle; that byte is lost.
            state_d  = ST_IDLE;
            len_d    = '0;
            csum_d   = '0;
            widx_d   = '0;
            to_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && (bus.rx_data == SYNC_BYTE)) begin
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (accept) begin
                        if ((bus.rx_data == 8'd0) || (int'(bus.rx_data) > int'(DEPTH))) begin
                            state_d = ST_ERR;
                        end else begin
                            len_d   = bus.rx_data;
                            widx_d  = '0;
                            csum_d  = '0;
                            state_d = ST_LO;
                        end
                    end
                end
                ST_LO: begin
                    if (accept) begin
                        lo_d    = bus.rx_data;
                        csum_d  = csum_q + bus.rx_data;
                        state_d = ST_HI;
                    end
                end
                ST_HI: begin
                    if (accept) begin
                        csum_d      = csum_q + bus.rx_data;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ADDR_W'(widx_q);
                        mem_wdata_d = {bus.rx_data, lo_q};
                        widx_d      = widx_q + 8'd1;
                        state_d     = (widx_q == (len_q - 8'd1)) ? ST_CSUM : ST_LO;
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        state_d = (bus.rx_data == csum_q) ? ST_RUN : ST_ERR;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase

            // Inter-byte watchdog, only armed while a frame is in progress.
            if (!in_frame || accept) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                to_cnt_d = '0;
                state_d  = ST_ERR;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end

        // Outputs are registered from the next state so they change on the
        // same edge as the state itself.
        rx_ready_d  = (state_d != ST_RUN) && (state_d != ST_ERR);
        cpu_rst_n_d = (state_d == ST_RUN);
        boot_mode_d = (state_d != ST_RUN);
        status_d    = state_status(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            lo_q        <= '0;
            csum_q      <= '0;
            widx_q      <= '0;
            to_cnt_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rx_ready_q  <= 1'b1;
            cpu_rst_n_q <= 1'b0;
            boot_mode_q <= 1'b1;
            status_q    <= STATUS_IDLE;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            lo_q        <= lo_d;
            csum_q      <= csum_d;
            widx_q      <= widx_d;
            to_cnt_q    <= to_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rx_ready_q  <= rx_ready_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            boot_mode_q <= boot_mode_d;
            status_q    <= status_d;
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_rst_n     = cpu_rst_n_q;
    assign boot_mode     = boot_mode_q;
    assign status        = status_q;

    // Drop the enable in the abort cycle so no tick escapes while the CPU
    // is being put back into reset.
    assign run_en = (state_q == ST_RUN) && !load_req;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .enable    (run_en),
        .step_mode (step_mode),
        .step      (step),
        .cpu_ce    (cpu_ce)
    );

endmodule
`default_nettype wire

// File: tb/tb_prog_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_load_ctrl
//  Description : Self-checking bench for prog_load_ctrl: frame table, hand
//                sequences for timing corners, and randomized frames checked
//                against a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_load_ctrl;
    localparam int ADDR_W   = 10;
    localparam int DEPTH    = 4;
    localparam int TIMEOUT  = 16;
    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_req = 1'b0;
    logic       step_mode = 1'b0;
    logic       step = 1'b0;
    logic       cpu_rst_n, cpu_ce, boot_mode;
    logic [1:0] status;

    prog_load_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    prog_load_ctrl #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .TIMEOUT  (TIMEOUT),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .load_req  (load_req),
        .step_mode (step_mode),
        .step      (step),
        .cpu_rst_n (cpu_rst_n),
        .cpu_ce    (cpu_ce),
        .boot_mode (boot_mode),
        .status    (status)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [25:0] wq[$];
    logic [25:0] exp_w[0:3];

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) wq.push_back({bus.mem_addr, bus.mem_wdata});
    end

    typedef struct packed {
        logic [63:0] stream;
        logic [3:0]  nb;
        logic [1:0]  st;
        logic [1:0]  nw;
        logic [15:0] w0;
        logic [15:0] w1;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.rx_ready === 1'b1) begin
                @(posedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_byte: byte %0h not accepted, rx_ready %0b expected 1", b, bus.rx_ready);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_load();
        bus.rx_valid = 1'b0;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wq.delete();
    endtask

    task automatic check_result(input string tag, input logic [1:0] st, input int nw);
        logic [25:0] act;
        chk({tag, "/status"}, 32'(status), 32'(st));
        chk({tag, "/nwrites"}, 32'(wq.size()), 32'(nw));
        for (int i = 0; i < nw; i++) begin
            act = (i < wq.size()) ? wq[i] : 26'h3FFFFFF;
            chk({tag, "/write"}, 32'(act), 32'(exp_w[i]));
        end
        chk({tag, "/cpu_rst_n"}, 32'(cpu_rst_n), 32'(st == 2'b10));
        chk({tag, "/boot_mode"}, 32'(boot_mode), 32'(st != 2'b10));
        chk({tag, "/rx_ready"}, 32'(bus.rx_ready), 32'(st < 2'b10));
    endtask

    task automatic send_happy();
        send_byte(8'hA5); send_byte(8'h02);
        send_byte(8'hA1); send_byte(8'h00);
        send_byte(8'hB2); send_byte(8'h00);
        send_byte(8'h53);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, finished 0 expected 1");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] strm;
        logic [7:0]  s[0:10];
        logic [7:0]  sum;
        int          n, len, long_at, nw, npulses;
        bit          corrupt, prev;
        logic [1:0]  st;

        vecs[0] = '{64'hA502_A100_B200_5300, 4'd7, 2'b10, 2'd2, 16'h00A1, 16'h00B2};
        vecs[1] = '{64'hA501_1122_0000_0000, 4'd5, 2'b11, 2'd1, 16'h2211, 16'h0000};
        vecs[2] = '{64'hA500_0000_0000_0000, 4'd2, 2'b11, 2'd0, 16'h0000, 16'h0000};
        vecs[3] = '{64'hA505_0000_0000_0000, 4'd2, 2'b11, 2'd0, 16'h0000, 16'h0000};
        vecs[4] = '{64'h00FF_A501_3412_4600, 4'd7, 2'b10, 2'd1, 16'h1234, 16'h0000};
        vecs[5] = '{64'hA501_FFFF_FE00_0000, 4'd5, 2'b10, 2'd1, 16'hFFFF, 16'h0000};

        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #2;
        chk("reset/status", 32'(status), 32'h0);
        chk("reset/rx_ready", 32'(bus.rx_ready), 32'h1);
        chk("reset/mem_we", 32'(bus.mem_we), 32'h0);
        chk("reset/mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("reset/mem_wdata", 32'(bus.mem_wdata), 32'h0);
        chk("reset/cpu_rst_n", 32'(cpu_rst_n), 32'h0);
        chk("reset/cpu_ce", 32'(cpu_ce), 32'h0);
        chk("reset/boot_mode", 32'(boot_mode), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ---- frame table ----
        for (int c = 0; c < 6; c++) begin
            pulse_load();
            strm = vecs[c].stream;
            for (int i = 0; i < int'(vecs[c].nb); i++) send_byte(strm[63-8*i -: 8]);
            repeat (3) @(negedge clk);
            exp_w[0] = {10'd0, vecs[c].w0};
            exp_w[1] = {10'd1, vecs[c].w1};
            check_result($sformatf("vec%0d", c), vecs[c].st, int'(vecs[c].nw));
        end

        // ---- free-run ticks after a good load ----
        step_mode = 1'b0;
        pulse_load();
        send_happy();
        chk("freerun/entry_status", 32'(status), 32'h2);
        chk("freerun/entry_rst_n", 32'(cpu_rst_n), 32'h1);
        chk("freerun/entry_ce", 32'(cpu_ce), 32'h0);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            chk($sformatf("freerun/ce%0d", k), 32'(cpu_ce), 32'((k % TICK_DIV) == 0));
        end

        // ---- abort from RUN ----
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        chk("abort/cpu_rst_n", 32'(cpu_rst_n), 32'h0);
        chk("abort/rx_ready", 32'(bus.rx_ready), 32'h1);
        chk("abort/boot_mode", 32'(boot_mode), 32'h1);
        chk("abort/status", 32'(status), 32'h0);

        // ---- step mode ----
        step_mode = 1'b1;
        pulse_load();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        send_happy();
        chk("step/entry_status", 32'(status), 32'h2);
        prev = 0;
        npulses = 0;
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("step/ce%0d", k), 32'(cpu_ce), 32'(prev));
            if (cpu_ce === 1'b1) npulses++;
            step = (k == 2) || (k == 7) || (k == 12);
            prev = step;
            @(negedge clk);
        end
        step = 1'b0;
        chk("step/npulses", 32'(npulses), 32'd3);
        step_mode = 1'b0;

        // ---- timeout mid-frame ----
        pulse_load();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hA1);
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            if (k == TIMEOUT - 1) chk("timeout/before", 32'(status), 32'h1);
        end
        chk("timeout/after", 32'(status), 32'h3);
        chk("timeout/nwrites", 32'(wq.size()), 32'h0);

        // ---- garbage in IDLE ----
        pulse_load();
        send_byte(8'h00); send_byte(8'hFF);
        chk("garbage/status", 32'(status), 32'h0);

        // ---- load_req beats a simultaneous sync byte ----
        pulse_load();
        bus.rx_data = 8'hA5; bus.rx_valid = 1'b1; load_req = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0; load_req = 1'b0;
        @(negedge clk);
        chk("abort_sync/status", 32'(status), 32'h0);

        // ---- load_req beats a simultaneous hi byte: no write ----
        pulse_load();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hA1);
        bus.rx_data = 8'hB2; bus.rx_valid = 1'b1; load_req = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0; load_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_hi/nwrites", 32'(wq.size()), 32'h0);
        chk("abort_hi/status", 32'(status), 32'h0);

        // ---- asynchronous reset while a write is on the bus ----
        pulse_load();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h34); send_byte(8'h12);
        chk("arst/mem_we_before", 32'(bus.mem_we), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst/mem_we", 32'(bus.mem_we), 32'h0);
        chk("arst/mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("arst/mem_wdata", 32'(bus.mem_wdata), 32'h0);
        chk("arst/status", 32'(status), 32'h0);
        chk("arst/rx_ready", 32'(bus.rx_ready), 32'h1);
        chk("arst/boot_mode", 32'(boot_mode), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ---- randomized frames vs. frame-level model ----
        for (int it = 0; it < 25; it++) begin
            n = $urandom_range(1, DEPTH);
            len = 2 * n + 3;
            s[0] = 8'hA5;
            s[1] = 8'(n);
            sum = 8'h00;
            for (int i = 0; i < 2 * n; i++) begin
                s[2+i] = 8'($urandom);
                sum = sum + s[2+i];
            end
            corrupt = ($urandom_range(0, 3) == 0);
            s[len-1] = corrupt ? sum + 8'($urandom_range(1, 255)) : sum;
            long_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len - 1) : -1;
            for (int w = 0; w < n; w++) exp_w[w] = {10'(w), s[3+2*w], s[2+2*w]};
            if (long_at >= 0) begin
                st = 2'b11;
                nw = (long_at > 2) ? (long_at - 2) / 2 : 0;
            end else begin
                st = corrupt ? 2'b11 : 2'b10;
                nw = n;
            end
            pulse_load();
            for (int j = 0; j < len; j++) begin
                if (j == long_at) begin
                    repeat (TIMEOUT + 4) @(negedge clk);
                    break;
                end
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send_byte(s[j]);
            end
            repeat (3) @(negedge clk);
            check_result($sformatf("rand%0d", it), st, nw);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_load_ctrl.md
Name: prog_load_ctrl

Overview:
- Sequences the 8-bit LED CPU from power-up to execution.
- Receives a program image over a byte stream and writes it word-by-word into the 16-bit instruction memory.
- Holds the CPU in reset with boot_mode asserted while loading, then releases it.
- Schedules CPU execution: free-running at a divided tick rate, or single-step from a button pulse.

Parameters:
- ADDR_W, 10: instruction memory word-address width. The CPU's 11-bit byte pc maps to word address pc[10:1].
- DEPTH, 1024: maximum image length in words. Must be ≤ 2**ADDR_W.
- TIMEOUT, 1_000_000: maximum clk cycles allowed between accepted bytes while mid-frame.
- TICK_DIV, 4_000_000: clk cycles per cpu_ce pulse in free-run mode. Must be ≥ 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  incoming byte (for example from a UART receiver)
- rx_valid  in  1  rx_data is valid; the byte is accepted on rx_valid & rx_ready
- rx_ready  out  1  controller can accept a byte
- load_req  in  1  single-cycle synchronous pulse: abort the current state and (re)enter loading
- step_mode  in  1  1 = single-step, 0 = free-run
- step  in  1  single-cycle pulse that advances one instruction in step mode
- mem_we  out  1  instruction memory write strobe
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  16  write data {hi, lo}
- cpu_rst_n  out  1  CPU reset, active-low
- cpu_ce  out  1  CPU clock-enable pulse
- boot_mode  out  1  high while not in RUN
- status  out  2  00 idle, 01 loading, 10 run, 11 error

Behaviour:
- Reset values:
  - State: IDLE.
  - rx_ready = 1.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - cpu_rst_n = 0, cpu_ce = 0, boot_mode = 1, status = 00.
  - All counters = 0.
- Frame format: 0xA5, N, then N words each sent as lo byte followed by hi byte, then checksum. The checksum is the 8-bit sum of the 2N data bytes, modulo 256.
- States: IDLE, LEN, LO, HI, CSUM, RUN, ERR. All transitions are registered.
- IDLE: accepted 0xA5 -> LEN. Any other accepted byte is discarded; stay in IDLE.
- LEN:
  - N == 0 or N > DEPTH -> ERR.
  - Otherwise latch N, clear word index and checksum -> LO.
- LO: latch the byte, add it to the checksum -> HI.
- HI: add the byte to the checksum and write the word:
  - On the cycle after acceptance, mem_we = 1 for exactly 1 cycle, with mem_addr = word index and mem_wdata = {hi, lo}.
  - Then increment the word index.
  - If this was word N-1 -> CSUM; else -> LO.
- CSUM:
  - Byte equals the checksum -> RUN.
  - Mismatch -> ERR.
  - Memory already written is not rolled back.
- rx_ready is 1 in IDLE, LEN, LO, HI and CSUM; 0 in RUN and ERR.
- Timeout: in LEN, LO, HI and CSUM, a counter clears on every accepted byte. When it reaches TIMEOUT -> ERR. The counter is inactive in IDLE.
- RUN:
  - cpu_rst_n goes to 1 on the first cycle in RUN; boot_mode goes to 0 on the same cycle.
  - cpu_ce is never asserted on the same cycle that cpu_rst_n rises. The first pulse comes at least 1 cycle later.
  - Free-run: a divider counts 0..TICK_DIV-1. cpu_ce = 1 for 1 cycle when the count equals TICK_DIV-1, then the count wraps to 0. The divider is cleared on RUN entry.
  - Step mode: cpu_ce is step registered (1-cycle latency), exactly 1 pulse per step pulse. A step arriving while not in RUN is ignored.
  - Toggling step_mode mid-run clears the divider. No cpu_ce is emitted on the toggle cycle.
- ERR: cpu_rst_n = 0, boot_mode = 1, status = 11. Stays in ERR until load_req.
- load_req, from any state:
  - Next state is IDLE; cpu_rst_n = 0 and boot_mode = 1 on the next cycle; all counters cleared.
  - load_req has priority over a byte accepted on the same cycle; that byte is dropped.
  - A pending mem_we already registered still completes.
- status mapping: IDLE -> 00; LEN, LO, HI, CSUM -> 01; RUN -> 10; ERR -> 11.
- Asserting rst mid-frame: all outputs return to their reset values immediately (asynchronous), including mem_we = 0.

Decomposition:
- Shared package prog_load_pkg holds:
  - the state enum (state_t);
  - SYNC_BYTE = 8'hA5;
  - the status encodings.
- One sub-module, tick_gen, holds the TICK_DIV divider plus the step/free-run mux and produces cpu_ce. Its inputs are enable (RUN), step_mode and step.

Test Plan:
1. Happy path: stream A5 02 A1 00 B2 00 53 -> mem writes (0, 0x00A1) and (1, 0x00B2), each 1 cycle. Then status = 10, cpu_rst_n = 1, boot_mode = 0. With TICK_DIV = 4, cpu_ce pulses every 4 cycles.
2. Bad checksum: stream A5 01 11 22 00 -> 1 write (0, 0x2211), then status = 11 with cpu_rst_n held 0. A later load_req -> status = 00.
3. Length errors: A5 00 -> ERR. With DEPTH = 4, A5 05 -> ERR. No mem_we occurs in either case.
4. Timeout: with TIMEOUT = 16, send A5 02 A1, then idle 16 cycles -> ERR at cycle 16. Garbage bytes 0x00 and 0xFF sent in IDLE cause no state change.
5. Step mode: after a good load with step_mode = 1, 3 step pulses -> exactly 3 cpu_ce pulses, each 1 cycle after its step. No cpu_ce occurs without a step.
6. Abort: load_req in RUN -> cpu_rst_n = 0 next cycle, rx_ready = 1. A load_req coinciding with an accepted 0xA5 leaves the state in IDLE.
